// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer driving one shared external full-adder cell.
// Adds two WIDTH-bit operands LSB first, one bit pair per clock.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last;
    logic             load;

    assign last = (cnt == CW'(WIDTH - 1));
    // A new request is taken in IDLE or straight out of DONE (back-to-back)
    assign load = start && (state == IDLE || state == DONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = start ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: adder cell is fed only while adding, idle-low otherwise
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        fa_a = 1'b0;
        fa_b = 1'b0;
        fa_c = 1'b0;
        unique case (state)
            ADD: begin
                busy = 1'b1;
                fa_a = a_sh[0];
                fa_b = b_sh[0];
                fa_c = carry;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Operand shifters, carry, bit counter and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            carry <= cin;
            cnt   <= '0;
        end else if (state == ADD) begin
            a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
            b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            // Results only move on the final bit, so they hold during a new add
            if (last) begin
                sum  <= {fa_s, sum_sh[WIDTH-1:1]};
                cout <= fa_cout;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with a behavioural full adder
// on the fa_* port and an arithmetic reference for every result.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         cin = 1'b0;
    logic         fa_a, fa_b, fa_c;
    logic         fa_s, fa_cout;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // Shared full-adder cell
    assign {fa_cout, fa_s} = 2'(fa_a) + 2'(fa_b) + 2'(fa_c);

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .op_a(op_a), .op_b(op_b), .cin(cin),
        .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
        .fa_s(fa_s), .fa_cout(fa_cout),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; return edges from accept to done, busy-cycle
    // count, LSB-first fa_a sequence. Result regs checked against prev
    // values while the new add is in flight.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W:0] prev,
                          output int lat, output int bcnt,
                          output logic [W-1:0] aseq);
        int n;
        start = 1'b1; op_a = a; op_b = b; cin = c;
        tick();
        start = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        n = 1; bcnt = 0; aseq = '0;
        check("hold_during_add", {23'd0, cout, sum}, {23'd0, prev});
        while (!done && n < 20) begin
            if (busy) begin
                if (bcnt < W) aseq[bcnt] = fa_a;
                bcnt++;
            end
            tick();
            n++;
        end
        lat = n;
        if (!done) check("done_timeout", 32'(done), 32'd1);
    endtask

    initial begin
        int lat, bc, n, seen;
        logic [W-1:0] aseq;
        logic [W:0] exp, prev;
        logic [W-1:0] ra, rb;
        logic rc;

        #1;
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum", 32'(sum), 0);
        check("reset_fa", {29'd0, fa_a, fa_b, fa_c}, 0);
        #20;
        @(negedge clk);
        rst = 1'b0;
        tick();

        // 1: zeros
        run_op(8'h00, 8'h00, 1'b0, 9'h000, lat, bc, aseq);
        check("t1_latency", 32'(lat), W + 1);
        check("t1_sum", {23'd0, cout, sum}, 32'h000);
        prev = 9'h000;

        // 2: overflow into cout
        run_op(8'hFF, 8'h01, 1'b0, prev, lat, bc, aseq);
        check("t2_busy_cycles", 32'(bc), W);
        exp = 9'(8'hFF) + 9'(8'h01);
        check("t2_sum", {23'd0, cout, sum}, 32'(exp));
        prev = exp;

        // 3: alternating pattern with carry in
        run_op(8'hA5, 8'h5A, 1'b1, prev, lat, bc, aseq);
        check("t3_fa_a_seq", 32'(aseq), 32'h0A5);
        exp = 9'(8'hA5) + 9'(8'h5A) + 9'd1;
        check("t3_sum", {23'd0, cout, sum}, 32'(exp));
        tick();
        check("t3_fa_idle", {29'd0, fa_a, fa_b, fa_c}, 0);

        // 4: start while busy must be ignored
        start = 1'b1; op_a = 8'd3; op_b = 8'd4; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; op_a = 8'd9; op_b = 8'd9;
        tick();
        start = 1'b0;
        n = 0;
        while (!done && n < 20) begin tick(); n++; end
        check("t4_done_seen", 32'(done), 1);
        check("t4_sum", {23'd0, cout, sum}, 32'h007);
        tick();
        check("t4_no_requeue", 32'(busy), 0);

        // 5: async reset mid-add
        start = 1'b1; op_a = 8'h11; op_b = 8'h22; cin = 1'b0;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 0);
        check("t5_done", 32'(done), 0);
        check("t5_sum", {23'd0, cout, sum}, 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen++;
        end
        check("t5_no_done", 32'(seen), 0);

        // 6: start held high through DONE
        start = 1'b1; op_a = 8'd1; op_b = 8'd1; cin = 1'b0;
        tick();
        op_a = 8'd2; op_b = 8'd2;
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        check("t6_first_at", 32'(n), 9);
        check("t6_first_sum", {23'd0, cout, sum}, 32'h002);
        tick();
        start = 1'b0;
        n++;
        check("t6_b2b_busy", 32'(busy), 1);
        while (!done && n < 30) begin tick(); n++; end
        check("t6_second_at", 32'(n), 18);
        check("t6_second_sum", {23'd0, cout, sum}, 32'h004);
        prev = 9'h004;
        tick();

        // Random operations against arithmetic reference
        for (int i = 0; i < 25; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            exp = 9'(ra) + 9'(rb) + 9'(rc);
            run_op(ra, rb, rc, prev, lat, bc, aseq);
            check("rnd_latency", 32'(lat), W + 1);
            check("rnd_fa_a_seq", 32'(aseq), 32'(ra));
            check("rnd_sum", {23'd0, cout, sum}, 32'(exp));
            prev = exp;
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
